// File: rtl/tick_ctrl_pkg.sv
// tick_ctrl_pkg
//   Shared types and helpers for the tick_controller slice.
//   - state_t     : controller state encoding (IDLE, RUN, PAUSE)
//   - RATE_*      : rate_sel encodings
//   - rate_reload : maps (rate_sel, DIV_FULL) to the divider reload value R
package tick_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] RATE_FAST = 2'b00;  // R = 0, tick every cycle
  localparam logic [1:0] RATE_X1   = 2'b01;  // R = DIV_FULL-1
  localparam logic [1:0] RATE_X2   = 2'b10;  // R = 2*DIV_FULL-1
  localparam logic [1:0] RATE_X4   = 2'b11;  // R = 4*DIV_FULL-1

  // Wide enough for any legal divider; callers size-cast to their DIV_W.
  localparam int RELOAD_W = 32;

  function automatic logic [RELOAD_W-1:0] rate_reload(input logic [1:0] sel,
                                                      input int unsigned div_full);
    logic [RELOAD_W-1:0] full;
    full = RELOAD_W'(div_full);
    case (sel)
      RATE_FAST: return '0;
      RATE_X1:   return full - RELOAD_W'(1);
      RATE_X2:   return (full << 1) - RELOAD_W'(1);
      RATE_X4:   return (full << 2) - RELOAD_W'(1);
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/tick_controller_if.sv
// tick_controller_if
//   Control/status bundle between the switch/key front end and tick_controller.
//   master : drives start/stop/clear/step/rate_sel/up_down, observes status
//   slave  : the controller; consumes controls, drives tick/count/tc/running
interface tick_controller_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       step;
  logic [1:0] rate_sel;
  logic       up_down;
  logic       tick;
  logic [3:0] count;
  logic       tc;
  logic       running;

  modport master (
    output start, stop, clear, step, rate_sel, up_down,
    input  tick, count, tc, running
  );

  modport slave (
    input  start, stop, clear, step, rate_sel, up_down,
    output tick, count, tc, running
  );
endinterface

// File: rtl/tick_divider.sv
// tick_divider
//   Loadable down-counter used as the rate divider.
//   Ports:
//     clock, reset : posedge clock, synchronous active-high reset (value -> 0)
//     load         : load load_val this edge (wins over dec_en)
//     load_val     : value to load
//     dec_en       : decrement by one this edge (saturates at zero)
//     value        : current divider value
//     zero         : value == 0
module tick_divider #(
  parameter int DIV_W = 28
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec_en,
  output logic [DIV_W-1:0] value,
  output logic             zero
);

  logic [DIV_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec_en && !zero) begin
      value_d = value_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/tick_controller.sv
// tick_controller
//   Run/pause/step sequencer for the rate-divided 4-bit hex counter.
//   Ports:
//     clock, reset : posedge clock, synchronous active-high reset
//     bus (slave)  : start/stop/clear/step/rate_sel/up_down in,
//                    tick/count/tc/running out (all outputs registered)
//   Parameters: DIV_FULL (cycles per base period), DIV_W (divider width,
//   must hold 4*DIV_FULL-1).
//   Build option: define TICK_CTRL_AUTOSTOP_EN to make a wrapping RUN tick
//   drop the controller into PAUSE.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped after reset/clear; start loads R, step ticks once
//   RUN   | divider counts down, tick and reload when it reaches zero
//   PAUSE | divider frozen; start resumes from held value, step ticks
module tick_controller
  import tick_ctrl_pkg::*;
#(
  parameter int unsigned DIV_FULL = 50_000_000,
  parameter int          DIV_W    = 28
) (
  input  logic            clock,
  input  logic            reset,
  tick_controller_if.slave bus
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] r_q, r_d;
  logic [3:0]       count_q, count_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             running_q, running_d;

  logic             div_load;
  logic             div_dec;
  logic [DIV_W-1:0] div_load_val;
  logic [DIV_W-1:0] div_value;
  logic             div_zero;
  logic [DIV_W-1:0] reload_val;
  logic             do_tick;
  logic             wrap;

  // Divider value is only observed through the zero flag; keep it on the
  // port for debug taps.
  logic             div_value_unused;
  assign div_value_unused = ^div_value;

  assign reload_val = DIV_W'(rate_reload(bus.rate_sel, DIV_FULL));

  tick_divider #(.DIV_W(DIV_W)) u_divider (
    .clock    (clock),
    .reset    (reset),
    .load     (div_load),
    .load_val (div_load_val),
    .dec_en   (div_dec),
    .value    (div_value),
    .zero     (div_zero)
  );

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    count_d      = count_q;
    tick_d       = 1'b0;
    tc_d         = 1'b0;
    div_load     = 1'b0;
    div_dec      = 1'b0;
    div_load_val = '0;
    do_tick      = 1'b0;
    wrap         = 1'b0;

    if (bus.clear) begin
      state_d      = IDLE;
      count_d      = 4'd0;
      div_load     = 1'b1;
      div_load_val = '0;
    end else begin
      // stop outranks start and step in every state, so a held stop
      // blocks both even where it has no transition of its own.
      case (state_q)
        IDLE: begin
          if (!bus.stop) begin
            if (bus.start) begin
              state_d      = RUN;
              r_d          = reload_val;
              div_load     = 1'b1;
              div_load_val = reload_val;
            end else if (bus.step) begin
              do_tick = 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (div_zero) begin
            do_tick      = 1'b1;
            r_d          = reload_val;
            div_load     = 1'b1;
            div_load_val = reload_val;
          end else begin
            div_dec = 1'b1;
          end
        end
        PAUSE: begin
          if (!bus.stop) begin
            if (bus.start) begin
              state_d = RUN;
            end else if (bus.step) begin
              do_tick = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (do_tick) begin
        tick_d = 1'b1;
        if (bus.up_down) begin
          count_d = count_q + 4'd1;
          wrap    = (count_q == 4'hF);
        end else begin
          count_d = count_q - 4'd1;
          wrap    = (count_q == 4'h0);
        end
        tc_d = wrap;
`ifdef TICK_CTRL_AUTOSTOP_EN
        // Only divider-driven wraps stop the run; step wraps leave state alone.
        if (wrap && (state_q == RUN)) begin
          state_d = PAUSE;
        end
`endif
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      r_q       <= '0;
      count_q   <= 4'd0;
      tick_q    <= 1'b0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      tc_q      <= tc_d;
      running_q <= running_d;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_tick_controller.sv
// tb_tick_controller
//   Directed bench for tick_controller with DIV_FULL=4.
//   Observed vector obs = {tick, tc, running, count[3:0]}.
module tb_tick_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_controller_if bus_if ();

  tick_controller #(.DIV_FULL(4), .DIV_W(5)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] obs;
  assign obs = {bus_if.tick, bus_if.tc, bus_if.running, bus_if.count};

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    bus_if.clear = 1'b0;
    bus_if.step  = 1'b0;
  endtask

  task automatic do_clear();
    bus_if.clear = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b000_0000) begin
      bad++; $display("FAIL clear_state obs=%b exp=%b", obs, 7'b000_0000);
    end
    bus_if.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b1; bus_if.step = 1'b1; bus_if.rate_sel = 2'b11; bus_if.up_down = 1'b1;
    clk_edge(); clk_edge();
    total++;
    if (obs !== 7'b000_0000) begin
      bad++; $display("FAIL reset_state obs=%b exp=%b", obs, 7'b000_0000);
    end
    rst = 1'b0;
    bus_if.start = 1'b0;
    clk_edge();
    total++;
    if (obs !== 7'b100_0001) begin
      bad++; $display("FAIL idle_step1 obs=%b exp=%b", obs, 7'b100_0001);
    end
    clk_edge();
    total++;
    if (obs !== 7'b100_0010) begin
      bad++; $display("FAIL idle_step2 obs=%b exp=%b", obs, 7'b100_0010);
    end
    rst = 1'b1;
    bus_if.start = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b000_0000) begin
      bad++; $display("FAIL reset_override obs=%b exp=%b", obs, 7'b000_0000);
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_run_x1();
    logic [6:0] exp;
    bus_if.rate_sel = 2'b01; bus_if.up_down = 1'b1; bus_if.start = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b001_0000) begin
      bad++; $display("FAIL run_start obs=%b exp=%b", obs, 7'b001_0000);
    end
    bus_if.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      for (int j = 1; j <= 4; j++) begin
        clk_edge();
        exp = (j == 4) ? {3'b101, 4'(k)} : {3'b001, 4'(k - 1)};
        total++;
        if (obs !== exp) begin
          bad++; $display("FAIL run_x1 k=%0d j=%0d obs=%b exp=%b", k, j, obs, exp);
        end
      end
    end
    do_clear();
  endtask

  task automatic test_fast_down();
    logic [6:0] exp;
    rst = 1'b1; clk_edge(); rst = 1'b0;
    bus_if.rate_sel = 2'b00; bus_if.up_down = 1'b0; bus_if.start = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b001_0000) begin
      bad++; $display("FAIL fast_start obs=%b exp=%b", obs, 7'b001_0000);
    end
    bus_if.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      clk_edge();
      exp = {1'b1, (k == 1), 1'b1, 4'(16 - k)};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL fast_down k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    do_clear();
  endtask

  task automatic test_pause_resume();
    bus_if.rate_sel = 2'b01; bus_if.up_down = 1'b1; bus_if.start = 1'b1;
    clk_edge();
    bus_if.start = 1'b0;
    clk_edge(); clk_edge();
    total++;
    if (obs !== 7'b001_0000) begin
      bad++; $display("FAIL pr_prestop obs=%b exp=%b", obs, 7'b001_0000);
    end
    bus_if.stop = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b000_0000) begin
      bad++; $display("FAIL pr_stop obs=%b exp=%b", obs, 7'b000_0000);
    end
    bus_if.stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_edge();
      total++;
      if (obs !== 7'b000_0000) begin
        bad++; $display("FAIL pr_paused i=%0d obs=%b exp=%b", i, obs, 7'b000_0000);
      end
    end
    bus_if.start = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b001_0000) begin
      bad++; $display("FAIL pr_resume obs=%b exp=%b", obs, 7'b001_0000);
    end
    bus_if.start = 1'b0;
    clk_edge();
    total++;
    if (obs !== 7'b001_0000) begin
      bad++; $display("FAIL pr_resume1 obs=%b exp=%b", obs, 7'b001_0000);
    end
    clk_edge();
    total++;
    if (obs !== 7'b101_0001) begin
      bad++; $display("FAIL pr_resume_tick obs=%b exp=%b", obs, 7'b101_0001);
    end
    do_clear();
  endtask

  task automatic test_step_wrap();
    bus_if.up_down = 1'b0; bus_if.step = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b110_1111) begin
      bad++; $display("FAIL sw_idle_down obs=%b exp=%b", obs, 7'b110_1111);
    end
    bus_if.step = 1'b0;
    bus_if.rate_sel = 2'b11; bus_if.start = 1'b1;
    clk_edge();
    bus_if.start = 1'b0; bus_if.stop = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b000_1111) begin
      bad++; $display("FAIL sw_paused obs=%b exp=%b", obs, 7'b000_1111);
    end
    bus_if.stop = 1'b0;
    bus_if.up_down = 1'b1; bus_if.step = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b110_0000) begin
      bad++; $display("FAIL sw_wrap obs=%b exp=%b", obs, 7'b110_0000);
    end
    clk_edge();
    total++;
    if (obs !== 7'b100_0001) begin
      bad++; $display("FAIL sw_held1 obs=%b exp=%b", obs, 7'b100_0001);
    end
    clk_edge();
    total++;
    if (obs !== 7'b100_0010) begin
      bad++; $display("FAIL sw_held2 obs=%b exp=%b", obs, 7'b100_0010);
    end
    bus_if.step = 1'b0;
    clk_edge();
    total++;
    if (obs !== 7'b000_0010) begin
      bad++; $display("FAIL sw_release obs=%b exp=%b", obs, 7'b000_0010);
    end
    // Still in PAUSE: resume keeps held divider (15), so no tick at rate 00.
    bus_if.rate_sel = 2'b00; bus_if.start = 1'b1;
    clk_edge();
    bus_if.start = 1'b0;
    clk_edge();
    total++;
    if (obs !== 7'b001_0010) begin
      bad++; $display("FAIL sw_still_paused obs=%b exp=%b", obs, 7'b001_0010);
    end
    do_clear();
  endtask

  task automatic test_priority();
    bus_if.up_down = 1'b1; bus_if.step = 1'b1;
    clk_edge();
    bus_if.step = 1'b0;
    bus_if.rate_sel = 2'b01; bus_if.start = 1'b1;
    clk_edge();
    bus_if.start = 1'b0; bus_if.step = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b001_0001) begin
      bad++; $display("FAIL pri_step_in_run obs=%b exp=%b", obs, 7'b001_0001);
    end
    bus_if.step = 1'b0; bus_if.stop = 1'b1; bus_if.start = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b000_0001) begin
      bad++; $display("FAIL pri_stop_start obs=%b exp=%b", obs, 7'b000_0001);
    end
    bus_if.stop = 1'b0; bus_if.start = 1'b0;
    bus_if.clear = 1'b1; bus_if.step = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b000_0000) begin
      bad++; $display("FAIL pri_clear_step obs=%b exp=%b", obs, 7'b000_0000);
    end
    bus_if.clear = 1'b0; bus_if.step = 1'b0;
    bus_if.rate_sel = 2'b00; bus_if.start = 1'b1;
    clk_edge();
    bus_if.start = 1'b0; bus_if.clear = 1'b1;
    clk_edge();
    total++;
    if (obs !== 7'b000_0000) begin
      bad++; $display("FAIL pri_clear_on_tick obs=%b exp=%b", obs, 7'b000_0000);
    end
    bus_if.clear = 1'b0;
  endtask

  task automatic test_rate_change();
    bus_if.up_down = 1'b1; bus_if.rate_sel = 2'b01; bus_if.start = 1'b1;
    clk_edge();
    bus_if.start = 1'b0; bus_if.rate_sel = 2'b00;
    for (int j = 1; j <= 3; j++) begin
      clk_edge();
      total++;
      if (obs !== 7'b001_0000) begin
        bad++; $display("FAIL rc_wait j=%0d obs=%b exp=%b", j, obs, 7'b001_0000);
      end
    end
    clk_edge();
    total++;
    if (obs !== 7'b101_0001) begin
      bad++; $display("FAIL rc_first_tick obs=%b exp=%b", obs, 7'b101_0001);
    end
    bus_if.up_down = 1'b0;
    clk_edge();
    total++;
    if (obs !== 7'b101_0000) begin
      bad++; $display("FAIL rc_fast_down obs=%b exp=%b", obs, 7'b101_0000);
    end
    clk_edge();
    total++;
    if (obs !== 7'b111_1111) begin
      bad++; $display("FAIL rc_down_wrap obs=%b exp=%b", obs, 7'b111_1111);
    end
    do_clear();
  endtask

  task automatic test_run_wrap();
    logic [6:0] exp;
    logic       run_exp;
    bus_if.up_down = 1'b1; bus_if.rate_sel = 2'b00; bus_if.start = 1'b1;
    clk_edge();
    bus_if.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      clk_edge();
`ifdef TICK_CTRL_AUTOSTOP_EN
      run_exp = (k != 16);
`else
      run_exp = 1'b1;
`endif
      exp = {1'b1, (k == 16), run_exp, 4'(k)};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL run_wrap k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    clk_edge();
`ifdef TICK_CTRL_AUTOSTOP_EN
    exp = 7'b000_0000;
`else
    exp = 7'b101_0001;
`endif
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL run_wrap_after obs=%b exp=%b", obs, exp);
    end
    do_clear();
  endtask

  initial begin
    idle_inputs();
    bus_if.rate_sel = 2'b00;
    bus_if.up_down  = 1'b1;
    test_reset();
    test_run_x1();
    test_fast_down();
    test_pause_resume();
    test_step_wrap();
    test_priority();
    test_rate_change();
    test_run_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
